// File: rtl/axi_adder_seq_pkg.sv
// Shared types and constants for the AXI4-Lite adder job sequencer.
package axi_adder_seq_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_RESP_W = 2;
    localparam int unsigned CNT_W      = 16;

    localparam logic [31:0] OFF_OP_A = 32'h0000_0000;
    localparam logic [31:0] OFF_OP_B = 32'h0000_0004;
    localparam logic [31:0] OFF_SUM  = 32'h0000_0008;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_SUM,
        RESP
    } seq_state_t;

endpackage

// File: rtl/axi_adder_sequencer_if.sv
// AXI4-Lite bus between the sequencer (master) and the adder peripheral (slave).
interface axi_adder_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_adder_lite_xfer.sv
// Single-beat AXI4-Lite master: one write (AW+W, then B) or one read (AR, then R) per start.
module axi_adder_lite_xfer
    import axi_adder_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_read,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  done_c,
    output logic [DATA_W-1:0]     rdata_c,
    output logic                  resp_err_c,
    axi_adder_sequencer_if.master m_axi
);

    assign m_axi.wstrb  = '1;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    // bready/rready are only high while their own transfer is outstanding
    assign done_c     = (m_axi.bvalid && m_axi.bready) || (m_axi.rvalid && m_axi.rready);
    assign rdata_c    = m_axi.rdata;
    assign resp_err_c = m_axi.rready ? (m_axi.rresp != AXI_RESP_OKAY)
                                     : (m_axi.bresp != AXI_RESP_OKAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.rready  <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.wdata   <= '0;
            m_axi.araddr  <= '0;
        end else begin
            // each VALID drops independently after its own handshake
            if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
            if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
            if (m_axi.arvalid && m_axi.arready) m_axi.arvalid <= 1'b0;
            if (done_c) begin
                m_axi.bready <= 1'b0;
                m_axi.rready <= 1'b0;
            end
            if (start) begin
                if (is_read) begin
                    m_axi.araddr  <= addr;
                    m_axi.arvalid <= 1'b1;
                    m_axi.rready  <= 1'b1;
                end else begin
                    m_axi.awaddr  <= addr;
                    m_axi.wdata   <= wdata;
                    m_axi.awvalid <= 1'b1;
                    m_axi.wvalid  <= 1'b1;
                    m_axi.bready  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_adder_sequencer.sv
// AXI4-Lite master running one adder job per command: write A, write B, read sum, respond.
module axi_adder_sequencer
    import axi_adder_seq_pkg::*;
#(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_a,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_sum,
    output logic                          rsp_err,
    output logic [CNT_W-1:0]              jobs_done,
    output logic [CNT_W-1:0]              jobs_err,
    axi_adder_sequencer_if.master         m_axi
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    localparam logic [AW-1:0] ADDR_A   = C_BASE_ADDR + AW'(OFF_OP_A);
    localparam logic [AW-1:0] ADDR_B   = C_BASE_ADDR + AW'(OFF_OP_B);
    localparam logic [AW-1:0] ADDR_SUM = C_BASE_ADDR + AW'(OFF_SUM);

    seq_state_t    state;
    logic [DW-1:0] op_b;

    logic          xfer_start_c;
    logic          xfer_is_read_c;
    logic [AW-1:0] xfer_addr_c;
    logic [DW-1:0] xfer_wdata_c;
    logic          xfer_done_c;
    logic [DW-1:0] xfer_rdata_c;
    logic          xfer_err_c;

    // Next transfer launches in the same cycle the previous one completes,
    // so operand A goes straight from cmd_a and only B needs latching.
    always_comb begin
        xfer_start_c   = 1'b0;
        xfer_is_read_c = 1'b0;
        xfer_addr_c    = ADDR_A;
        xfer_wdata_c   = cmd_a;
        case (state)
            IDLE: xfer_start_c = cmd_valid;
            WR_A: begin
                xfer_start_c = xfer_done_c && !xfer_err_c;
                xfer_addr_c  = ADDR_B;
                xfer_wdata_c = op_b;
            end
            WR_B: begin
                xfer_start_c   = xfer_done_c && !xfer_err_c;
                xfer_is_read_c = 1'b1;
                xfer_addr_c    = ADDR_SUM;
                xfer_wdata_c   = '0;
            end
            default: ;
        endcase
    end

    axi_adder_lite_xfer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_xfer (
        .clk        (ACLK),
        .rst        (ARESET),
        .start      (xfer_start_c),
        .is_read    (xfer_is_read_c),
        .addr       (xfer_addr_c),
        .wdata      (xfer_wdata_c),
        .done_c     (xfer_done_c),
        .rdata_c    (xfer_rdata_c),
        .resp_err_c (xfer_err_c),
        .m_axi      (m_axi)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
            jobs_done <= '0;
            jobs_err  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_b      <= cmd_b;
                    rsp_err   <= 1'b0;
                    rsp_sum   <= '0;
                    cmd_ready <= 1'b0;
                    state     <= WR_A;
                end
                WR_A: if (xfer_done_c) begin
                    if (xfer_err_c) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= WR_B;
                    end
                end
                WR_B: if (xfer_done_c) begin
                    if (xfer_err_c) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= RD_SUM;
                    end
                end
                RD_SUM: if (xfer_done_c) begin
                    rsp_sum   <= xfer_err_c ? '0 : xfer_rdata_c;
                    rsp_err   <= xfer_err_c;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    jobs_done <= jobs_done + CNT_W'(1);
                    if (rsp_err) jobs_err <= jobs_err + CNT_W'(1);
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_adder_sequencer.sv
// Directed and randomized checks of the adder sequencer against a behavioural adder slave.
module tb_axi_adder_sequencer;
    import axi_adder_seq_pkg::*;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_a, cmd_b, rsp_sum;
    logic [15:0] jobs_done, jobs_err;

    always #5 clk = ~clk;

    axi_adder_sequencer_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_adder_sequencer #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (32'h0000_0000)
    ) dut (
        .ACLK      (clk),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .jobs_done (jobs_done),
        .jobs_err  (jobs_err),
        .m_axi     (axi)
    );

    // ---------------- adder slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic        b_err = 1'b0, r_err = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_q = '0, w_q = '0;
    logic [31:0] regs [4];
    int          n_aw = 0, n_ar = 0, n_wr = 0;
    logic [31:0] wlog_addr [256];
    logic [31:0] wlog_data [256];

    wire aw_hs = axi.awvalid & axi.awready;
    wire w_hs  = axi.wvalid & axi.wready;
    wire ar_hs = axi.arvalid & axi.arready;
    wire [31:0] waddr_c = aw_hs ? axi.awaddr : aw_q;
    wire [31:0] wdata_c = w_hs ? axi.wdata : w_q;

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
    assign axi.arready = axi.arvalid && !axi.rvalid && (ar_cnt >= ar_dly);

    always @(posedge clk) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
            if (aw_hs) begin aw_cnt <= 0; aw_got <= 1'b1; aw_q <= axi.awaddr; n_aw <= n_aw + 1; end
            if (axi.wvalid && !axi.wready) w_cnt <= w_cnt + 1;
            if (w_hs) begin w_cnt <= 0; w_got <= 1'b1; w_q <= axi.wdata; end
            if (!axi.bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                axi.bvalid <= 1'b1;
                axi.bresp  <= b_err ? 2'b10 : 2'b00;
                regs[waddr_c[3:2]] <= wdata_c;
                wlog_addr[n_wr % 256] <= waddr_c;
                wlog_data[n_wr % 256] <= wdata_c;
                n_wr <= n_wr + 1;
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
            if (ar_hs) begin
                ar_cnt     <= 0;
                n_ar       <= n_ar + 1;
                axi.rvalid <= 1'b1;
                axi.rdata  <= regs[0] + regs[1];
                axi.rresp  <= r_err ? 2'b10 : 2'b00;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // address/data must hold while VALID waits for READY
    int          stab_viol = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_pa = '0, w_pd = '0, ar_pa = '0;
    always @(posedge clk) begin
        if (!ARESET) begin
            if (aw_pend && (!axi.awvalid || axi.awaddr !== aw_pa)) stab_viol <= stab_viol + 1;
            if (w_pend && (!axi.wvalid || axi.wdata !== w_pd))     stab_viol <= stab_viol + 1;
            if (ar_pend && (!axi.arvalid || axi.araddr !== ar_pa)) stab_viol <= stab_viol + 1;
        end
        aw_pend <= axi.awvalid && !axi.awready && !ARESET;
        w_pend  <= axi.wvalid && !axi.wready && !ARESET;
        ar_pend <= axi.arvalid && !axi.arready && !ARESET;
        aw_pa <= axi.awaddr; w_pd <= axi.wdata; ar_pa <= axi.araddr;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    int bp_viol = 0;

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int bp,
                           output logic [31:0] sum, output logic err, output int lat);
        int n;
        int snap_aw, snap_ar;
        rsp_ready = (bp == 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < 300) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        sum = rsp_sum; err = rsp_err;
        if (bp > 0) begin
            snap_aw = n_aw; snap_ar = n_ar;
            repeat (bp) begin
                @(negedge clk);
                if (!rsp_valid || rsp_sum !== sum || rsp_err !== err || cmd_ready ||
                    axi.awvalid || axi.wvalid || axi.arvalid || n_aw != snap_aw || n_ar != snap_ar)
                    bp_viol++;
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] a, b;
        int          aw_d, w_d, ar_d;
        logic        berr, rerr;
        logic [31:0] sum;
        logic        err;
        int          nwr, nrd;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] sum, s1, ra, rb;
    logic        err;
    int          lat, wr0, ar0, first, second;
    logic [15:0] exp_done = '0, exp_err = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0007, 0, 0, 0, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 2, 1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 2, 1};
        vecs[2] = '{32'h1234_5678, 32'h1111_1111, 3, 1, 2, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 2, 1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 5, 0, 5, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2, 1};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0001, 0, 5, 1, 1'b0, 1'b0, 32'hDEAD_BEF0, 1'b0, 2, 1};
        vecs[5] = '{32'h0000_0001, 32'h0000_0001, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1, 0};
        vecs[6] = '{32'h0000_0030, 32'h0000_0004, 1, 1, 1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 2, 1};

        ARESET = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); ARESET = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_axi_ctrl", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        check("rst_awaddr", axi.awaddr, 32'd0);
        check("rst_araddr", axi.araddr, 32'd0);
        check("rst_wdata", axi.wdata, 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check("rst_rsp_sum", rsp_sum, 32'd0);
        check("rst_counters", {jobs_done, jobs_err}, 32'd0);
        check("wstrb_prot", 32'({axi.wstrb, axi.awprot, axi.arprot}), 32'h3C0);

        for (int i = 0; i < 7; i++) begin
            aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; ar_dly = vecs[i].ar_d;
            b_err = vecs[i].berr; r_err = vecs[i].rerr;
            wr0 = n_wr; ar0 = n_ar;
            run_job(vecs[i].a, vecs[i].b, 0, sum, err, lat);
            exp_done++;
            if (vecs[i].err) exp_err++;
            @(negedge clk);
            check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d_nwr", i), n_wr - wr0, vecs[i].nwr);
            check($sformatf("v%0d_nrd", i), n_ar - ar0, vecs[i].nrd);
            if (vecs[i].nwr >= 1) begin
                check($sformatf("v%0d_wa_addr", i), wlog_addr[wr0 % 256], 32'h0);
                check($sformatf("v%0d_wa_data", i), wlog_data[wr0 % 256], vecs[i].a);
            end
            if (vecs[i].nwr >= 2) begin
                check($sformatf("v%0d_wb_addr", i), wlog_addr[(wr0 + 1) % 256], 32'h4);
                check($sformatf("v%0d_wb_data", i), wlog_data[(wr0 + 1) % 256], vecs[i].b);
            end
            if (i == 0) check("v0_latency", lat, 7);
            check($sformatf("v%0d_jobs_done", i), 32'(jobs_done), 32'(exp_done));
            check($sformatf("v%0d_jobs_err", i), 32'(jobs_err), 32'(exp_err));
            check($sformatf("v%0d_rsp_drop", i), 32'(rsp_valid), 32'd0);
        end
        b_err = 1'b0; r_err = 1'b0;

        // response backpressure for 10 cycles
        aw_dly = 1; w_dly = 2; ar_dly = 0;
        run_job(32'h0000_0100, 32'h0000_0023, 10, sum, err, lat);
        exp_done++;
        @(negedge clk);
        check("bp_sum", sum, 32'h0000_0123);
        check("bp_stable", bp_viol, 0);
        check("bp_jobs_done", 32'(jobs_done), 32'(exp_done));

        // back-to-back jobs with cmd_valid and rsp_ready held high
        aw_dly = 0; w_dly = 0; ar_dly = 0; rsp_ready = 1'b1;
        first = -1; second = -1; s1 = '0;
        @(negedge clk); cmd_valid = 1'b1; cmd_a = 32'd3; cmd_b = 32'd4;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (first < 0) begin first = c; s1 = rsp_sum; end
                else begin second = c; cmd_valid = 1'b0; break; end
            end
        end
        cmd_valid = 1'b0;
        exp_done += 2;
        @(negedge clk);
        check("b2b_first_latency", first, 7);
        check("b2b_spacing", second - first, 8);
        check("b2b_sum", s1, 32'd7);
        check("b2b_jobs_done", 32'(jobs_done), 32'(exp_done));

        // randomized ready delays
        for (int j = 0; j < 100; j++) begin
            aw_dly = $urandom_range(5, 0); w_dly = $urandom_range(5, 0); ar_dly = $urandom_range(5, 0);
            ra = $urandom(); rb = $urandom();
            run_job(ra, rb, 0, sum, err, lat);
            exp_done++;
            check($sformatf("rnd%0d_sum", j), sum, ra + rb);
            check($sformatf("rnd%0d_err", j), 32'(err), 32'd0);
        end
        @(negedge clk);
        check("rnd_jobs_done", 32'(jobs_done), 32'(exp_done));
        check("rnd_jobs_err", 32'(jobs_err), 32'(exp_err));
        check("addr_data_stable", stab_viol, 0);

        // reset while the sum read is outstanding
        aw_dly = 0; w_dly = 0; ar_dly = 4; rsp_ready = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_a = 32'd9; cmd_b = 32'd1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int n = 0; n < 100 && !axi.arvalid; n++) @(negedge clk);
        check("mid_rst_in_rd", 32'(axi.arvalid), 32'd1);
        ARESET = 1'b1;
        @(posedge clk); #1 ARESET = 1'b0;
        @(negedge clk);
        check("mid_rst_arvalid", 32'(axi.arvalid), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_counters", {jobs_done, jobs_err}, 32'd0);
        exp_done = '0; exp_err = '0;
        ar_dly = 0;
        run_job(32'd9, 32'd1, 0, sum, err, lat);
        exp_done++;
        @(negedge clk);
        check("post_rst_sum", sum, 32'd10);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_jobs_done", 32'(jobs_done), 32'(exp_done));
        check("post_rst_jobs_err", 32'(jobs_err), 32'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
